fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Parametrised instruction-fetch stage with a built-in F/D pipeline register.
- Holds the PC and reads a word-addressed instruction memory.
- Assembles two-word instructions: an opcode word plus an immediate word.
- Takes branch/jump redirects, stalls and bubble insertion, and vectors to an interrupt handler at instruction boundaries.
- Sits between the hazard/branch logic and the decode stage.

Parameters:
- PC_W, 32, program-counter width.
- ADDR_W, 19, memory index width; depth is 2**ADDR_W words.
- INSTR_W, 16, instruction word width.
- RESET_PC, 32, PC value loaded on reset; first non-interrupt-reserved address.
- IRQ_VEC_ADDR, 0, memory address holding the interrupt handler address.
- IMM_BIT, 15, opcode-word bit that marks a two-word instruction.
- NOP_WORD, 16'h4000, encoding driven on a bubble.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze PC, FSM and output register.
- bubble  in  1  hold PC/FSM; load a bubble into the output register.
- redirect  in  1  load redirect_pc into PC; discard in-flight work.
- redirect_pc  in  PC_W  target address.
- irq  in  1  interrupt request, level-sensitive.
- irq_ack  out  1  one-cycle pulse when the vector fetch starts.
- irq_ret_pc  out  PC_W  PC of the next unexecuted instruction, captured at irq_ack.
- instr  out  INSTR_W  registered opcode word to decode.
- imm  out  INSTR_W  registered immediate word; 0 for one-word instructions.
- instr_valid  out  1  instr/imm hold a real instruction.
- pc_plus_one  out  PC_W  address after the last word of the issued instruction.

Behaviour:
- Memory: internal array; combinational read of mem[pc[ADDR_W-1:0]]; preloaded by the bench.
- Output register (latency 1 cycle):
  - Reset values: instr=NOP_WORD, imm=0, instr_valid=0, pc_plus_one=0, irq_ack=0, irq_ret_pc=0.
  - A "bubble" means instr=NOP_WORD, imm=0, instr_valid=0; pc_plus_one holds.
- PC arithmetic: modulo 2**PC_W. Memory index uses the low ADDR_W bits only, so the index wraps.
- FSM states are FETCH, IMM and VECTOR. Reset puts the FSM in FETCH with pc=RESET_PC.
- Per-cycle priority: reset > redirect > stall > bubble > FSM action.
  - redirect: pc<=redirect_pc, state<=FETCH, held opcode discarded, output register gets a bubble. Same cycle as stall: redirect wins.
  - stall: every register holds, outputs included; irq_ack=0.
  - bubble: pc and state hold; output register gets a bubble.
- FETCH:
  - irq=1: irq_ret_pc<=pc, irq_ack<=1, state<=VECTOR, output bubble.
  - Else, word has IMM_BIT=1: latch the word internally, pc<=pc+1, state<=IMM, output bubble.
  - Else: instr<=word, imm<=0, instr_valid<=1, pc_plus_one<=pc+1, pc<=pc+1.
- IMM:
  - instr<=latched opcode, imm<=word, instr_valid<=1, pc_plus_one<=pc+1, pc<=pc+1, state<=FETCH.
  - irq is ignored in IMM; interrupts are only taken at instruction boundaries.
- VECTOR:
  - pc<=zero-extended mem[IRQ_VEC_ADDR], state<=FETCH, output bubble.
  - irq is not re-sampled in VECTOR; the handler's first instruction is fetched next.
- irq_ack is high exactly one cycle per accepted interrupt. The requester must drop irq after the ack, otherwise the interrupt is re-taken at the next FETCH boundary.
- Reset mid-operation (any state, including IMM with a latched opcode) returns to FETCH with pc=RESET_PC and all outputs at reset values.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two 32-bit output ports are added:
  - perf_instr_cnt: incremented on every cycle that loads instr_valid=1.
  - perf_bubble_cnt: incremented on every non-stall cycle that loads a bubble.
  - Both clear on reset and wrap at 2**32.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, IMM, VECTOR}.
  - NOP_WORD default constant.
  - Default RESET_PC and IRQ_VEC_ADDR constants.
- Sub-module instr_mem: parametrised ADDR_W/INSTR_W array with two combinational read ports (pc port and vector port).

Test Plan:
1. Reset, mem[32..34]=0x1001,0x1002,0x1003 -> instr 0x1001/0x1002/0x1003 on cycles 1-3 after reset release; pc_plus_one 33/34/35; instr_valid=1.
2. mem[32]=0x8005, mem[33]=0x00AB -> one bubble, then instr=0x8005, imm=0x00AB, pc_plus_one=34.
3. redirect=1 with redirect_pc=0x100 while in IMM -> bubble, held opcode dropped; next instr=mem[0x100].
4. stall held 3 cycles mid-stream -> outputs frozen and pc unchanged; bubble 1 cycle -> one NOP with valid=0, then the same instruction re-issued.
5. mem[0]=0x0200, irq=1 at pc=40 in FETCH -> irq_ack pulse, irq_ret_pc=40, two bubbles, then instr=mem[0x200]; irq during IMM is deferred until the pair issues.
6. reset asserted in IMM, plus the wrap case: pc=2**19-1 with ADDR_W=19 -> reset gives pc=32 and outputs at reset values; the wrap case reads mem[2**19-1], then mem[0] with pc_plus_one=2**19+1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH,
      IMM,
      VECTOR
   } fetch_state_t;

   localparam logic [15:0] DEF_NOP_WORD     = 16'h4000;
   localparam int unsigned DEF_RESET_PC     = 32;
   localparam int unsigned DEF_IRQ_VEC_ADDR = 0;

endpackage

// File: rtl/fetch_unit_instr_mem.sv
// Word-addressed instruction store with two combinational read ports
// (sequential fetch and interrupt-vector lookup); contents are preloaded.
module instr_mem #(
   parameter int unsigned ADDR_W  = 19,
   parameter int unsigned INSTR_W = 16
) (
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic [INSTR_W-1:0] pc_word,
   input  logic [ADDR_W-1:0]  vec_addr,
   output logic [INSTR_W-1:0] vec_word
);

   logic [INSTR_W-1:0] mem [2**ADDR_W];

   assign pc_word  = mem[pc_addr];
   assign vec_word = mem[vec_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with F/D output register, two-word instruction
// assembly and interrupt vectoring. Optional macro: FETCH_PERF_CNT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned          PC_W         = 32,
   parameter int unsigned          ADDR_W       = 19,
   parameter int unsigned          INSTR_W      = 16,
   parameter logic [PC_W-1:0]      RESET_PC     = PC_W'(DEF_RESET_PC),
   parameter int unsigned          IRQ_VEC_ADDR = DEF_IRQ_VEC_ADDR,
   parameter int unsigned          IMM_BIT      = 15,
   parameter logic [INSTR_W-1:0]   NOP_WORD     = INSTR_W'(DEF_NOP_WORD)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               bubble,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               irq,
   output logic               irq_ack,
   output logic [PC_W-1:0]    irq_ret_pc,
   output logic [INSTR_W-1:0] instr,
   output logic [INSTR_W-1:0] imm,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc_plus_one
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_instr_cnt,
   output logic [31:0]        perf_bubble_cnt
`endif
);

   fetch_state_t       state;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_inc;
   logic [INSTR_W-1:0] held_op;
   logic [INSTR_W-1:0] word;
   logic [INSTR_W-1:0] vec_word;

   assign pc_inc = pc + PC_W'(1);

   instr_mem #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_mem (
      .pc_addr  (pc[ADDR_W-1:0]),
      .pc_word  (word),
      .vec_addr (ADDR_W'(IRQ_VEC_ADDR)),
      .vec_word (vec_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         held_op     <= '0;
         instr       <= NOP_WORD;
         imm         <= '0;
         instr_valid <= 1'b0;
         pc_plus_one <= '0;
         irq_ack     <= 1'b0;
         irq_ret_pc  <= '0;
      end else if (redirect) begin
         state       <= FETCH;
         pc          <= redirect_pc;
         instr       <= NOP_WORD;
         imm         <= '0;
         instr_valid <= 1'b0;
         irq_ack     <= 1'b0;
      end else if (stall) begin
         irq_ack     <= 1'b0;
      end else if (bubble) begin
         instr       <= NOP_WORD;
         imm         <= '0;
         instr_valid <= 1'b0;
         irq_ack     <= 1'b0;
      end else begin
         irq_ack <= 1'b0;
         case (state)
            FETCH: begin
               if (irq) begin
                  irq_ret_pc  <= pc;
                  irq_ack     <= 1'b1;
                  state       <= VECTOR;
                  instr       <= NOP_WORD;
                  imm         <= '0;
                  instr_valid <= 1'b0;
               end else if (word[IMM_BIT]) begin
                  held_op     <= word;
                  pc          <= pc_inc;
                  state       <= IMM;
                  instr       <= NOP_WORD;
                  imm         <= '0;
                  instr_valid <= 1'b0;
               end else begin
                  instr       <= word;
                  imm         <= '0;
                  instr_valid <= 1'b1;
                  pc_plus_one <= pc_inc;
                  pc          <= pc_inc;
               end
            end
            IMM: begin
               instr       <= held_op;
               imm         <= word;
               instr_valid <= 1'b1;
               pc_plus_one <= pc_inc;
               pc          <= pc_inc;
               state       <= FETCH;
            end
            VECTOR: begin
               pc          <= PC_W'(vec_word);
               state       <= FETCH;
               instr       <= NOP_WORD;
               imm         <= '0;
               instr_valid <= 1'b0;
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic perf_load_instr;
   logic perf_load_bubble;

   // Mirrors the priority chain above to classify what the output register loads.
   always_comb begin
      perf_load_instr  = 1'b0;
      perf_load_bubble = 1'b0;
      if (!reset) begin
         if (redirect) begin
            perf_load_bubble = 1'b1;
         end else if (!stall) begin
            if (bubble || state == VECTOR) begin
               perf_load_bubble = 1'b1;
            end else if (state == IMM) begin
               perf_load_instr = 1'b1;
            end else if (irq || word[IMM_BIT]) begin
               perf_load_bubble = 1'b1;
            end else begin
               perf_load_instr = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_instr_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (perf_load_instr)  perf_instr_cnt  <= perf_instr_cnt + 32'd1;
         if (perf_load_bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
